pc_unit_ras: RTL and testbench

PC_UNIT_RAS -- requirements
Module: pc_unit_ras

---
 rtl/pc_unit_ras.sv | 88 ++++++++
 tb/tb_pc_unit_ras.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Program counter with priority-ordered next-PC selection and a small circular
// return-address stack that keeps the newest RAS_DEPTH entries.
module pc_unit_ras #(
  parameter int                ADDR_W     = 32,
  parameter int                INC        = 4,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [0:ADDR_W-1] branch_off,
  input  logic              jump_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [0:ADDR_W-1] jump_addr,
  output logic [0:ADDR_W-1] pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [0:ADDR_W-1] INC_V  = ADDR_W'(INC);
  localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(RAS_DEPTH);

  logic [0:ADDR_W-1] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic [0:ADDR_W-1] pc_seq;
  logic              do_ret;
  logic              do_push;

  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_C);
  assign pc_seq    = pc + INC_V;
  assign top_ptr   = wr_ptr - 1'b1;
  assign do_ret    = !rst && !stall && ret_en;
  assign do_push   = !rst && !stall && !ret_en && call_en;

  // wr_ptr always names the next free slot; when full it also names the oldest
  // entry, so a push there overwrites exactly the entry that should be lost.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[wr_ptr] <= pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    ras_ovf <= 1'b0;
    ras_unf <= 1'b0;
    if (rst) begin
      pc     <= RESET_ADDR;
      count  <= '0;
      wr_ptr <= '0;
    end else if (!stall) begin
      if (ret_en) begin
        if (ras_empty) begin
          pc      <= pc_seq;
          ras_unf <= 1'b1;
        end else begin
          pc     <= ras_mem[top_ptr];
          wr_ptr <= top_ptr;
          count  <= count - 1'b1;
        end
      end else if (call_en) begin
        pc     <= jump_addr;
        wr_ptr <= wr_ptr + 1'b1;
        if (ras_full) begin
          ras_ovf <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (jump_en) begin
        pc <= jump_addr;
      end else if (branch_en) begin
        pc <= pc + branch_off;
      end else begin
        pc <= pc_seq;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed and randomized checks of pc_unit_ras against a queue-based model.
module tb_pc_unit_ras;
  localparam int          DEPTH = 4;
  localparam logic [31:0] INC   = 32'd4;
  localparam logic [31:0] RST_A = 32'h0;

  localparam logic [5:0] C_RST = 6'b100000;
  localparam logic [5:0] C_STL = 6'b010000;
  localparam logic [5:0] C_RET = 6'b001000;
  localparam logic [5:0] C_CAL = 6'b000100;
  localparam logic [5:0] C_JMP = 6'b000010;
  localparam logic [5:0] C_BRA = 6'b000001;
  localparam logic [5:0] C_IDL = 6'b000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall = 1'b0, branch_en = 1'b0, jump_en = 1'b0;
  logic        call_en = 1'b0, ret_en = 1'b0;
  logic [0:31] branch_off = '0, jump_addr = '0, pc;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf;

  pc_unit_ras #(.ADDR_W(32), .INC(4), .RAS_DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en), .branch_off(branch_off),
    .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .jump_addr(jump_addr),
    .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive controls, advance the model, then compare after the edge.
  task automatic cyc(input logic [5:0] ctl, input logic [31:0] off, input logic [31:0] ja);
    logic [31:0] tmp;
    {rst, stall, ret_en, call_en, jump_en, branch_en} = ctl;
    branch_off = off;
    jump_addr  = ja;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (ctl[5]) begin
      m_pc = RST_A;
      m_stk.delete();
    end else if (!ctl[4]) begin
      if (ctl[3]) begin
        if (m_stk.size() == 0) begin
          m_pc  = m_pc + INC;
          m_unf = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (ctl[2]) begin
        m_stk.push_back(m_pc + INC);
        if (m_stk.size() > DEPTH) begin
          tmp   = m_stk.pop_front();
          m_ovf = 1'b1;
        end
        m_pc = ja;
      end else if (ctl[1]) m_pc = ja;
      else if (ctl[0]) m_pc = m_pc + off;
      else m_pc = m_pc + INC;
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("ras_empty", 32'(ras_empty), 32'(m_stk.size() == 0));
    check("ras_full", 32'(ras_full), 32'(m_stk.size() == DEPTH));
    check("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    check("ras_unf", 32'(ras_unf), 32'(m_unf));
  endtask

  logic [31:0] ret_exp[5];

  initial begin
    m_pc = 32'h0;
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34;
    ret_exp[3] = 32'h24; ret_exp[4] = 32'h28;

    // reset and sequential increment
    cyc(C_RST | C_JMP | C_CAL, 0, 32'h1234);
    check("reset_pc", pc, 32'h0);
    check("reset_empty", 32'(ras_empty), 32'd1);
    cyc(C_IDL, 0, 0); check("idle1", pc, 32'h4);
    cyc(C_IDL, 0, 0); check("idle2", pc, 32'h8);
    cyc(C_IDL, 0, 0); check("idle3", pc, 32'hC);

    // negative branch and increment wrap
    cyc(C_JMP, 0, 32'h100);
    cyc(C_BRA, 32'hFFFF_FFF0, 0); check("branch_neg", pc, 32'hF0);
    cyc(C_JMP, 0, 32'hFFFF_FFFC);
    cyc(C_IDL, 0, 0); check("inc_wrap", pc, 32'h0);

    // call / return round trip
    cyc(C_JMP, 0, 32'h200);
    cyc(C_CAL, 0, 32'h1000); check("call_pc", pc, 32'h1000);
    cyc(C_IDL, 0, 0);
    cyc(C_IDL, 0, 0);
    cyc(C_RET, 0, 0); check("ret_pc", pc, 32'h204);
    check("ret_empty", 32'(ras_empty), 32'd1);

    // five nested calls into a four-deep stack, then five returns
    for (int k = 1; k <= 5; k++) begin
      cyc(C_JMP, 0, 32'(k) * 32'h10);
      cyc(C_CAL, 0, 32'h4000 + 32'(k) * 32'h100);
      if (k == 4) check("full_after4", 32'(ras_full), 32'd1);
      check("ovf_call", 32'(ras_ovf), 32'(k == 5));
    end
    for (int k = 0; k < 5; k++) begin
      cyc(C_RET, 0, 0);
      check("nested_ret", pc, ret_exp[k]);
      check("nested_unf", 32'(ras_unf), 32'(k == 4));
    end

    // stall holds everything and blocks a pending jump
    cyc(C_JMP, 0, 32'h400);
    cyc(C_CAL, 0, 32'h900);
    cyc(C_STL | C_JMP, 0, 32'h800); check("stall1", pc, 32'h900);
    cyc(C_STL | C_JMP | C_RET, 0, 32'h800); check("stall2", pc, 32'h900);
    check("stall_cnt", 32'(ras_empty), 32'd0);
    cyc(C_JMP, 0, 32'h800); check("post_stall", pc, 32'h800);
    cyc(C_RET, 0, 0); check("stall_ret", pc, 32'h404);

    // ret beats call and jump; no push happens
    cyc(C_JMP, 0, 32'h2FC);
    cyc(C_CAL, 0, 32'h5000);
    cyc(C_RET | C_CAL | C_JMP, 0, 32'h7000); check("ret_wins", pc, 32'h300);
    check("ret_wins_empty", 32'(ras_empty), 32'd1);

    // reset during stall with a partly filled stack
    cyc(C_CAL, 0, 32'h600);
    cyc(C_CAL, 0, 32'h700);
    cyc(C_RST | C_STL, 0, 0); check("rst_in_stall", pc, RST_A);
    cyc(C_RET, 0, 0); check("rst_then_ret", pc, RST_A + INC);
    check("rst_then_unf", 32'(ras_unf), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] ctl;
      ctl = '0;
      ctl[5] = ($urandom_range(0, 49) == 0);
      ctl[4] = ($urandom_range(0, 7) == 0);
      ctl[3] = ($urandom_range(0, 3) == 0);
      ctl[2] = ($urandom_range(0, 2) == 0);
      ctl[1] = ($urandom_range(0, 5) == 0);
      ctl[0] = ($urandom_range(0, 3) == 0);
      cyc(ctl, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
